// File: rtl/traffic_pkg.sv
// Shared state encodings, lamp codes and lamp decode for the intersection phase scheduler.
// Lamps use the {R,G,B} encoding of the single-lamp traffic_light_controller.
package traffic_pkg;

    localparam int ST_W = 4;

    typedef logic [ST_W-1:0] state_t;

    localparam state_t ST_NS_GREEN  = 4'd0;
    localparam state_t ST_NS_YELLOW = 4'd1;
    localparam state_t ST_ALL_RED_1 = 4'd2;
    localparam state_t ST_EW_GREEN  = 4'd3;
    localparam state_t ST_EW_YELLOW = 4'd4;
    localparam state_t ST_ALL_RED_2 = 4'd5;
    localparam state_t ST_WALK      = 4'd6;
    localparam state_t ST_PED_CLR   = 4'd7;
    localparam state_t ST_EMERG_RED = 4'd8;

    localparam logic [2:0] LAMP_RED = 3'b100;
    localparam logic [2:0] LAMP_YEL = 3'b110;
    localparam logic [2:0] LAMP_GRN = 3'b010;
    localparam logic [2:0] LAMP_OFF = 3'b000;

    typedef struct packed {
        logic [2:0] ns;
        logic [2:0] ew;
        logic       walk;
    } lamps_t;

    // Anything not explicitly a go/caution phase shows red both ways.
    function automatic lamps_t lamps_for(input state_t st);
        lamps_t l;
        l.ns   = LAMP_RED;
        l.ew   = LAMP_RED;
        l.walk = 1'b0;
        case (st)
            ST_NS_GREEN:  l.ns   = LAMP_GRN;
            ST_NS_YELLOW: l.ns   = LAMP_YEL;
            ST_EW_GREEN:  l.ew   = LAMP_GRN;
            ST_EW_YELLOW: l.ew   = LAMP_YEL;
            ST_WALK:      l.walk = 1'b1;
            default:      l.walk = 1'b0;
        endcase
        return l;
    endfunction

    function automatic int max4(input int a, input int b, input int c, input int d);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        return m;
    endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Divides the board clock down to a one-cycle timing tick every TICK_DIV cycles.
// clr restarts the division so a phase always begins on a full tick period.
module tick_prescaler #(
    parameter int TICK_DIV = 100_000_000
) (
    input  logic clk_100MHz,
    input  logic rst_n,
    input  logic clr,
    output logic tick
);

    localparam int PS_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PS_W-1:0] PS_LAST = PS_W'(TICK_DIV - 1);

    logic [PS_W-1:0] r_cnt;
    logic            w_at_last;

    assign w_at_last = (r_cnt == PS_LAST);
    assign tick      = w_at_last;

    always_ff @(posedge clk_100MHz or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (clr || w_at_last) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/traffic_phase_scheduler.sv
// Two-direction intersection sequencer with pedestrian walk phase and emergency all-red.
// Lamp outputs are registered from the state register, so they trail it by one cycle.
//
//   state        | meaning
//   NS_GREEN     | NS go, EW red; may end early once a walk is pending
//   NS_YELLOW    | NS caution, always served in full
//   ALL_RED_1    | clearance before EW
//   EW_GREEN     | EW go, NS red; may end early once a walk is pending
//   EW_YELLOW    | EW caution, always served in full
//   ALL_RED_2    | clearance; branch to WALK or NS_GREEN
//   WALK         | pedestrian crossing, both red
//   PED_CLR      | clearance after the walk
//   EMERG_RED    | held all-red while emerg is high, then clearance
module traffic_phase_scheduler
    import traffic_pkg::*;
#(
    parameter int TICK_DIV  = 100_000_000,
    parameter int GREEN_T   = 10,
    parameter int GREEN_MIN = 4,
    parameter int YELLOW_T  = 3,
    parameter int ALLRED_T  = 1,
    parameter int WALK_T    = 5
) (
    input  logic       clk_100MHz,
    input  logic       rst_n,
    input  logic       ped_req,
    input  logic       emerg,
    output logic [2:0] ns_rgb,
    output logic [2:0] ew_rgb,
    output logic       walk,
    output logic       ped_pending,
    output logic [3:0] phase
);

    localparam int T_MAX = max4(GREEN_T, YELLOW_T, ALLRED_T, WALK_T);
    localparam int CNT_W = (T_MAX > 1) ? $clog2(T_MAX) : 1;

    // Tick-count values at which the final tick of each duration lands.
    localparam logic [CNT_W-1:0] GRN_LAST  = CNT_W'(GREEN_T - 1);
    localparam logic [CNT_W-1:0] GMIN_LAST = CNT_W'(GREEN_MIN - 1);
    localparam logic [CNT_W-1:0] YEL_LAST  = CNT_W'(YELLOW_T - 1);
    localparam logic [CNT_W-1:0] AR_LAST   = CNT_W'(ALLRED_T - 1);
    localparam logic [CNT_W-1:0] WALK_LAST = CNT_W'(WALK_T - 1);

    state_t           r_state;
    state_t           w_next;
    logic [CNT_W-1:0] r_tick_cnt;
    logic             w_tick;
    logic             w_clr;
    logic             r_ped_pending;
    logic             r_emerg_hold;
    logic [2:0]       r_ns_rgb;
    logic [2:0]       r_ew_rgb;
    logic             r_walk;
    lamps_t           w_lamps;

    logic             w_green_done;
    logic             w_yel_done;
    logic             w_ar_done;
    logic             w_walk_done;
    logic             w_to_emerg;
    state_t           w_after_clear;

    tick_prescaler #(
        .TICK_DIV (TICK_DIV)
    ) u_prescaler (
        .clk_100MHz (clk_100MHz),
        .rst_n      (rst_n),
        .clr        (w_clr),
        .tick       (w_tick)
    );

    assign w_green_done  = w_tick && ((r_tick_cnt == GRN_LAST) ||
                                      (r_ped_pending && (r_tick_cnt >= GMIN_LAST)));
    assign w_yel_done    = w_tick && (r_tick_cnt == YEL_LAST);
    assign w_ar_done     = w_tick && (r_tick_cnt == AR_LAST);
    assign w_walk_done   = w_tick && (r_tick_cnt == WALK_LAST);
    assign w_to_emerg    = emerg || r_emerg_hold;
    assign w_after_clear = r_ped_pending ? ST_WALK : ST_NS_GREEN;

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_NS_GREEN: begin
                if (emerg || w_green_done) w_next = ST_NS_YELLOW;
            end
            ST_NS_YELLOW: begin
                if (w_yel_done) w_next = w_to_emerg ? ST_EMERG_RED : ST_ALL_RED_1;
            end
            ST_ALL_RED_1: begin
                if (emerg)          w_next = ST_EMERG_RED;
                else if (w_ar_done) w_next = ST_EW_GREEN;
            end
            ST_EW_GREEN: begin
                if (emerg || w_green_done) w_next = ST_EW_YELLOW;
            end
            ST_EW_YELLOW: begin
                if (w_yel_done) w_next = w_to_emerg ? ST_EMERG_RED : ST_ALL_RED_2;
            end
            ST_ALL_RED_2: begin
                if (emerg)          w_next = ST_EMERG_RED;
                else if (w_ar_done) w_next = w_after_clear;
            end
            ST_WALK: begin
                if (emerg)            w_next = ST_EMERG_RED;
                else if (w_walk_done) w_next = ST_PED_CLR;
            end
            ST_PED_CLR: begin
                if (emerg)          w_next = ST_EMERG_RED;
                else if (w_ar_done) w_next = ST_NS_GREEN;
            end
            ST_EMERG_RED: begin
                if (!emerg && w_ar_done) w_next = w_after_clear;
            end
            default: w_next = ST_ALL_RED_2;
        endcase
    end

    // A high emerg in EMERG_RED keeps restarting the clearance countdown.
    assign w_clr = (w_next != r_state) || ((r_state == ST_EMERG_RED) && emerg);

    always_ff @(posedge clk_100MHz or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_ALL_RED_2;
            r_tick_cnt <= '0;
        end else begin
            r_state <= w_next;
            if (w_clr) begin
                r_tick_cnt <= '0;
            end else if (w_tick) begin
                r_tick_cnt <= r_tick_cnt + 1'b1;
            end
        end
    end

    // Clear on WALK entry beats a same-cycle request.
    always_ff @(posedge clk_100MHz or negedge rst_n) begin
        if (!rst_n) begin
            r_ped_pending <= 1'b0;
        end else if ((w_next == ST_WALK) && (r_state != ST_WALK)) begin
            r_ped_pending <= 1'b0;
        end else if (ped_req) begin
            r_ped_pending <= 1'b1;
        end
    end

    // Remembers an emergency seen during green/yellow so the yellow still ends in EMERG_RED
    // even if emerg drops before the yellow completes.
    always_ff @(posedge clk_100MHz or negedge rst_n) begin
        if (!rst_n) begin
            r_emerg_hold <= 1'b0;
        end else if (r_state == ST_EMERG_RED) begin
            r_emerg_hold <= 1'b0;
        end else if (emerg) begin
            r_emerg_hold <= 1'b1;
        end
    end

    assign w_lamps = lamps_for(r_state);

    always_ff @(posedge clk_100MHz or negedge rst_n) begin
        if (!rst_n) begin
            r_ns_rgb <= LAMP_RED;
            r_ew_rgb <= LAMP_RED;
            r_walk   <= 1'b0;
        end else begin
            r_ns_rgb <= w_lamps.ns;
            r_ew_rgb <= w_lamps.ew;
            r_walk   <= w_lamps.walk;
        end
    end

    assign ns_rgb      = r_ns_rgb;
    assign ew_rgb      = r_ew_rgb;
    assign walk        = r_walk;
    assign ped_pending = r_ped_pending;
    assign phase       = r_state;

endmodule
